// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants and state encoding for the register-file dump reader.
// The register geometry constants are also used by the register file and pipeline.
package regfile_dump_reader_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Register-file read port and {addr, data} output stream of the dump reader.
// The master side is the reader; the slave side is the register-file mux and the monitor.
interface regfile_dump_reader_if
  import regfile_dump_reader_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
);

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output rd_addr,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_addr,
    output out_data
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_addr,
    input  out_data
  );

endinterface

// File: rtl/regfile_dump_reader_stream_out_reg.sv
// One-entry valid/ready output register. A new beat is loaded only when the slot is
// empty or being consumed, so a stalled beat never changes.
module regfile_dump_reader_stream_out_reg #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              flush,
  input  logic              ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              can_load,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  assign can_load = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ld && can_load) begin
      valid <= 1'b1;
      addr  <= ld_addr;
      data  <= ld_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every register through a shared read port and streams {addr, data} beats.
// busy selects the external read-port mux toward this block.
//
//   state | meaning
//   IDLE  | waiting for start; read port not claimed
//   RUN   | reading registers 0..NUM_REGS-1, one per accepted load
//   DRAIN | last beat loaded, waiting for it to be accepted
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int NUM_REGS = REG_COUNT,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  regfile_dump_reader_if.master bus
);

  // One extra bit so the terminal compare cannot alias when NUM_REGS == 2**ADDR_W.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_REGS - 1);

  dump_state_e       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              done_nxt;
  logic              ld, flush, can_load;
  logic [ADDR_W-1:0] rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    ld        = 1'b0;
    flush     = 1'b0;
    rd_addr   = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        rd_addr = cnt[ADDR_W-1:0];
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          flush     = 1'b1;
        end else begin
          ld = 1'b1;
          if (can_load) begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == LAST) state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          flush     = 1'b1;
        end else if (bus.out_valid && bus.out_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        flush     = 1'b1;
      end
    endcase
  end

  assign busy        = (state != IDLE);
  assign bus.rd_addr = rd_addr;

  regfile_dump_reader_stream_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .flush    (flush),
    .ready    (bus.out_ready),
    .ld_addr  (cnt[ADDR_W-1:0]),
    .ld_data  (bus.rd_data),
    .can_load (can_load),
    .valid    (bus.out_valid),
    .addr     (bus.out_addr),
    .data     (bus.out_data)
  );

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/inspection reader for the 32x32 processor register file.
- On `start`, it walks every register through one read port (asynchronous read, combinational data return). It streams each {address, data} pair out on a valid/ready interface toward the testbench monitor or debug UART.
- It sits beside the pipeline and shares the register file's second read port through an external mux, selected while `busy`=1.
- It never writes the register file.

Parameters:
- NUM_REGS, 32, number of registers walked (addresses 0..NUM_REGS-1).
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin a dump; sampled only in IDLE.
- abort  input  1  terminate a dump in progress; no done pulse.
- busy  output  1  high in RUN and DRAIN; drives the external read-port mux select.
- done  output  1  one-cycle pulse after the last beat is accepted.
- rd_addr  output  ADDR_W  register file read address.
- rd_data  input  DATA_W  register file read data, combinational from rd_addr.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_addr  output  ADDR_W  register index of the current beat.
- out_data  output  DATA_W  register contents of the current beat.

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, rd_addr=0, busy=0, done=0, out_valid=0, out_addr=0, out_data=0.
  - Reset asserted mid-dump discards the dump: no done pulse, and out_valid drops immediately.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 at posedge -> RUN, cnt=0.
  - start is ignored in any other state.
- RUN:
  - rd_addr=cnt, combinationally.
  - load = !out_valid || out_ready.
  - On a posedge with load=1: out_data<=rd_data, out_addr<=cnt, out_valid<=1, cnt<=cnt+1.
  - If cnt==NUM_REGS-1 at that load -> DRAIN.
  - load=0: hold all output registers stable; cnt unchanged (backpressure).
- DRAIN:
  - When out_valid && out_ready: out_valid<=0, done<=1 for exactly one cycle, -> IDLE.
- Throughput: one beat per cycle with out_ready held high. The first beat is valid one cycle after RUN is entered.
- Stability rule: while out_valid=1 and out_ready=0, out_addr and out_data must not change.
- abort=1 in RUN or DRAIN at posedge: -> IDLE, out_valid<=0, cnt<=0, no done.
  - abort has priority over load and handshake in the same cycle.
  - abort in IDLE has no effect.
- cnt is ADDR_W+1 bits wide, so the terminal compare never aliases on wrap. Addresses emitted are strictly 0..NUM_REGS-1 in order, each exactly once.
- Coherency: the register file writes on negedge clk; this block samples rd_data on posedge. A beat therefore reflects all writes completed before the preceding negedge. No snapshot guarantee across the whole dump.
- busy = (state != IDLE).

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2);
  - REG_COUNT=32, REG_ADDR_W=5 and REG_DATA_W=32, reused by the register file and pipeline.
- One natural sub-module: stream_out_reg, a 1-entry valid/ready output register with a load-enable and a hold-under-backpressure rule. The FSM and counter remain in the top.

Test Plan:
- Full dump, no backpressure:
  - Stimulus: preload mem[i]=32'hA000_0000+i via the write port; start at T0; out_ready=1.
  - Response: beats addr 0..31 with data A0000000..A000001F on T1..T32, consecutive; done at T33; busy low after T33.
- Backpressure:
  - Stimulus: out_ready=0 during beats 5 and 6 for 3 cycles each.
  - Response: out_addr/out_data stay frozen at 5/A0000005 and 6/A0000006 while stalled; no beat dropped or duplicated; 32 beats total; done after the last accepted beat.
- Abort:
  - Stimulus: abort asserted the cycle beat 10 is valid and out_ready=1.
  - Response: out_valid=0 next cycle; state IDLE; no done.
  - A following start produces a full dump beginning at addr 0.
- Async reset mid-dump:
  - Stimulus: rst pulsed between clock edges during beat 20.
  - Response: out_valid, busy and done go to 0 immediately, with no clock edge required.
  - After release, start gives a complete, correct dump.
- Concurrent write coherency:
  - Stimulus: write mem[15]=32'hDEAD_BEEF at the negedge before beat 15 is captured.
  - Response: beat 15 carries DEADBEEF.
  - A write to mem[3] after beat 3 is captured does not alter any emitted beat.
- start ignored when busy:
  - Stimulus: pulse start during RUN and during DRAIN.
  - Response: the dump is unaffected; exactly 32 beats and one done pulse.
